// File: rtl/bus_protocol_pkg.sv
// Shared definitions for the bus protocol target: FSM states and
// protocol timing constants used by the target and its receive FIFO.
package bus_protocol_pkg;

    localparam int DATA_W        = 8;
    localparam int MAX_VALID_CYC = 4;
    localparam int MAX_ACK_DLY   = 3;

    // Width of the WAIT-cycle counter; it saturates at MAX_ACK_DLY.
    localparam int CNT_W = $clog2(MAX_ACK_DLY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        DRAIN
    } state_t;

endpackage

// File: rtl/bus_target_fifo.sv
// Receive FIFO for the bus protocol target: power-of-two depth,
// first-word fall-through head, simultaneous push/pop when full.
module bus_target_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = bus_protocol_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_cnt;
    logic              w_do_pop;
    logic              w_do_push;

    assign full      = (r_cnt == FULL_CNT);
    assign empty     = (r_cnt == '0);
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign w_do_push = push && (!full || w_do_pop);
    // Head reads as zero while empty so the output is clean during reset.
    assign head      = empty ? '0 : r_mem[r_rd];

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= push_data;
    end

endmodule

// File: rtl/bus_protocol_target.sv
// Bus protocol target: detects a dValid rising start, acks after
// ACK_DLY..3 cycles depending on FIFO space, and queues the data.
// Optional master protocol checker enabled by BUS_TARGET_PROTO_CHK_EN.
module bus_protocol_target
    import bus_protocol_pkg::*;
#(
    parameter int ACK_DLY = 1,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dValid,
    input  logic [DATA_W-1:0] data,
    output logic              dAck,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overflow,
    output logic              proto_err
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_prev;
    logic             r_dack;
    logic             r_ovf;
    logic             w_start;
    logic             w_pop;
    logic             w_space;
    logic             w_ack;
    logic             w_full;
    logic             w_empty;

    assign w_start   = dValid && !r_prev;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign w_space   = !w_full || w_pop;
    // Ack once the minimum delay has elapsed and there is room; the
    // last allowed cycle forces the ack even when the data must be dropped.
    assign w_ack     = (r_state == WAIT) && dValid &&
                       (((int'(r_cnt) >= ACK_DLY) && w_space) ||
                        (int'(r_cnt) == MAX_ACK_DLY));
    assign dAck      = r_dack;
    assign overflow  = r_ovf;

    // Next-state selection for the transfer handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = WAIT;
            WAIT: begin
                if (!dValid)    w_next = IDLE;
                else if (w_ack) w_next = ACK;
            end
            ACK:     w_next = DRAIN;
            DRAIN:   if (!dValid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, WAIT counter, dValid history and registered ack/overflow pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prev  <= 1'b1;   // a start needs dValid seen low after reset
            r_dack  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_prev  <= dValid;
            r_dack  <= w_ack;
            r_ovf   <= w_ack && !w_space;
            if (r_state == IDLE && w_start)
                r_cnt <= CNT_W'(1);
            else if (r_state == WAIT && int'(r_cnt) != MAX_ACK_DLY)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    bus_target_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_ack && w_space),
        .push_data (data),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (out_data)
    );

`ifdef BUS_TARGET_PROTO_CHK_EN
    logic [DATA_W-1:0] r_data_t0;
    logic              r_perr;
    logic              w_perr;

    // Violations: dValid drops before the ack, data moves while waiting,
    // or dValid is still high the cycle after the ack.
    always_comb begin
        w_perr = 1'b0;
        if (r_state == WAIT) begin
            if (!dValid)                 w_perr = 1'b1;
            else if (data != r_data_t0)  w_perr = 1'b1;
        end
        if (r_state == ACK && dValid)    w_perr = 1'b1;
    end

    // Capture the data presented at the start edge for the stability check.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_start) r_data_t0 <= data;
    end

    // Registered one-cycle violation pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_perr <= 1'b0;
        else          r_perr <= w_perr;
    end

    assign proto_err = r_perr;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_protocol_target.sv
// Bench for bus_protocol_target: three instances with ACK_DLY 1, 2, 3
// share stimulus and are compared against a transaction-level model.
module tb_bus_protocol_target;

`ifdef BUS_TARGET_PROTO_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       dValid;
    logic [7:0] data;
    logic       out_ready;
    logic       dack [3];
    logic       ovf  [3];
    logic       perr [3];
    logic       ov   [3];
    logic [7:0] od   [3];

    int checks = 0;
    int errors = 0;

    bus_protocol_target #(.ACK_DLY(1), .DEPTH(4)) u_d0 (
        .clk(clk), .reset_n(reset_n), .dValid(dValid), .data(data),
        .dAck(dack[0]), .out_valid(ov[0]), .out_data(od[0]),
        .out_ready(out_ready), .overflow(ovf[0]), .proto_err(perr[0]));
    bus_protocol_target #(.ACK_DLY(2), .DEPTH(4)) u_d1 (
        .clk(clk), .reset_n(reset_n), .dValid(dValid), .data(data),
        .dAck(dack[1]), .out_valid(ov[1]), .out_data(od[1]),
        .out_ready(out_ready), .overflow(ovf[1]), .proto_err(perr[1]));
    bus_protocol_target #(.ACK_DLY(3), .DEPTH(4)) u_d2 (
        .clk(clk), .reset_n(reset_n), .dValid(dValid), .data(data),
        .dAck(dack[2]), .out_valid(ov[2]), .out_data(od[2]),
        .out_ready(out_ready), .overflow(ovf[2]), .proto_err(perr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    bit         m_wait [3];   // start seen, ack not yet given
    int         m_k    [3];   // edges since the start edge
    int         m_post [3];   // 1: edge right after ack, 2: waiting for dValid low
    bit         m_prev [3];
    logic [7:0] m_t0d  [3];
    logic [7:0] m_fifo [3][4];
    int         m_n    [3];
    bit         m_dack [3];
    bit         m_ovf  [3];
    bit         m_perr [3];

    task automatic m_reset();
        for (int d = 0; d < 3; d++) begin
            m_wait[d] = 0; m_k[d] = 0; m_post[d] = 0; m_prev[d] = 1;
            m_n[d] = 0; m_dack[d] = 0; m_ovf[d] = 0; m_perr[d] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input logic [7:0] dat, input bit rdy);
        for (int d = 0; d < 3; d++) begin
            bit pop, space, push, pe;
            pop = (m_n[d] > 0) && rdy;
            space = (m_n[d] < 4) || pop;
            push = 0; pe = 0;
            m_dack[d] = 0; m_ovf[d] = 0;
            if (m_wait[d]) begin
                m_k[d]++;
                if (!v) begin
                    m_wait[d] = 0; pe = 1;
                end else begin
                    if (dat != m_t0d[d]) pe = 1;
                    if ((m_k[d] >= d + 1 && space) || m_k[d] >= 3) begin
                        m_dack[d] = 1; m_wait[d] = 0; m_post[d] = 1;
                        if (space) push = 1; else m_ovf[d] = 1;
                    end
                end
            end else if (m_post[d] == 1) begin
                if (v) pe = 1;
                m_post[d] = 2;
            end else if (m_post[d] == 2) begin
                if (!v) m_post[d] = 0;
            end else if (v && !m_prev[d]) begin
                m_wait[d] = 1; m_k[d] = 0; m_t0d[d] = dat;
            end
            m_prev[d] = v;
            if (pop) begin
                for (int i = 0; i < 3; i++) m_fifo[d][i] = m_fifo[d][i+1];
                m_n[d]--;
            end
            if (push) begin
                m_fifo[d][m_n[d]] = dat;
                m_n[d]++;
            end
            m_perr[d] = CHK && pe;
        end
    endtask

    function automatic logic [35:0] exp_vec();
        logic [35:0] r;
        for (int d = 0; d < 3; d++)
            r[d*12 +: 12] = {m_dack[d], m_ovf[d], m_perr[d], m_n[d] > 0,
                             (m_n[d] > 0) ? m_fifo[d][0] : 8'h00};
        return r;
    endfunction

    function automatic logic [35:0] obs_vec();
        logic [35:0] r;
        for (int d = 0; d < 3; d++)
            r[d*12 +: 12] = {dack[d], ovf[d], perr[d], ov[d], od[d]};
        return r;
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, settle.
    task automatic step(input bit v, input logic [7:0] dat, input bit rdy);
        dValid = v; data = dat; out_ready = rdy;
        @(posedge clk);
        model_edge(v, dat, rdy);
        #1;
    endtask

    // ------------------------------- tests -------------------------------
    task automatic test_reset();
        if (obs_vec() !== 36'h0) begin
            errors++; $display("FAIL reset_outputs obs=%h exp=%h", obs_vec(), 36'h0);
        end
        checks++;
        dValid = 1'b1; data = 8'h77;
        @(posedge clk); #1;
        if (obs_vec() !== 36'h0) begin
            errors++; $display("FAIL reset_hold obs=%h exp=%h", obs_vec(), 36'h0);
        end
        checks++;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h77, 0);
            if (dack[0] !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL no_start_after_reset cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 8'h00, 1);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_idle cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_basic_ack();
        step(1, 8'hA5, 0);                       // edge T0
        if (dack[0] !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL basic_t0 obs=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
        step(1, 8'hA5, 0);                       // edge T0+1
        if (dack[0] !== 1'b1 || ovf[0] !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL basic_ack obs=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
        step(0, 8'h00, 0);                       // edge T0+2
        if (dack[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== 8'hA5 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL basic_head dack=%b ov=%b od=%h exp_od=a5", dack[0], ov[0], od[0]);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL basic_drain cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_max_delay();
        for (int i = 0; i < 6; i++) begin
            step(i < 4, (i < 4) ? 8'h3C : 8'h00, 0);
            if (dack[2] !== (i == 3) || perr[2] !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL max_delay k=%0d dack=%b perr=%b obs=%h exp=%h", i, dack[2], perr[2], obs_vec(), exp_vec());
            end
            checks++;
        end
        if (od[2] !== 8'h3C) begin
            errors++; $display("FAIL max_delay_data obs=%h exp=3c", od[2]);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL max_drain cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic send(input logic [7:0] dat, input bit rdy_at_1, input string nm);
        for (int i = 0; i < 6; i++) begin
            step(i < 4, (i < 4) ? dat : 8'h00, rdy_at_1 && i == 1);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL %s k=%0d obs=%h exp=%h", nm, i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_backpressure();
        for (int j = 1; j <= 4; j++) send(8'(j), 0, "bp_fill");
        for (int i = 0; i < 6; i++) begin
            step(i < 4, (i < 4) ? 8'h05 : 8'h00, 0);
            if (dack[0] !== (i == 3) || ovf[0] !== (i == 3) || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL bp_overflow k=%0d dack=%b ovf=%b obs=%h exp=%h", i, dack[0], ovf[0], obs_vec(), exp_vec());
            end
            checks++;
        end
        for (int j = 1; j <= 4; j++) begin
            if (ov[0] !== 1'b1 || od[0] !== 8'(j)) begin
                errors++; $display("FAIL bp_order ov=%b od=%h exp=%h", ov[0], od[0], 8'(j));
            end
            checks++;
            step(0, 8'h00, 1);
        end
        if (ov[0] !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL bp_empty obs=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_pop_frees();
        logic [7:0] vals [5];
        for (int j = 0; j < 5; j++) vals[j] = 8'($urandom);
        for (int j = 0; j < 4; j++) send(vals[j], 0, "pf_fill");
        for (int i = 0; i < 6; i++) begin
            step(i < 4, (i < 4) ? vals[4] : 8'h00, i == 1);
            if (i == 1 && (dack[0] !== 1'b1 || ovf[0] !== 1'b0)) begin
                errors++; $display("FAIL pop_frees_ack dack=%b ovf=%b exp dack=1 ovf=0", dack[0], ovf[0]);
            end
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL pop_frees k=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks += (i == 1) ? 2 : 1;
        end
        for (int j = 1; j <= 4; j++) begin
            if (ov[0] !== 1'b1 || od[0] !== vals[j]) begin
                errors++; $display("FAIL pf_order ov=%b od=%h exp=%h", ov[0], od[0], vals[j]);
            end
            checks++;
            step(0, 8'h00, 1);
        end
        for (int i = 0; i < 2; i++) step(0, 8'h00, 1);
    endtask

    task automatic test_violation();
        step(1, 8'h9E, 0);                       // edge T0
        step(0, 8'h00, 0);                       // dValid low at T0+1
        if (dack[1] !== 1'b0 || perr[1] !== CHK || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL viol_pulse dack=%b perr=%b exp_perr=%b", dack[1], perr[1], CHK);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 0);
            if (dack[1] !== 1'b0 || perr[1] !== 1'b0 || ov[1] !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL viol_after cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        send(8'h11, 0, "rm_pre");
        step(1, 8'h22, 0);                       // edge T0
        reset_n = 1'b0; m_reset();               // low before T0+1
        #1;
        if (obs_vec() !== 36'h0) begin
            errors++; $display("FAIL reset_mid obs=%h exp=%h", obs_vec(), 36'h0);
        end
        checks++;
        dValid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        if (ov[0] !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_mid_nopush obs=%h exp=%h", obs_vec(), exp_vec());
        end
        checks++;
        test_basic_ack();
    endtask

    task automatic test_random();
        bit         v = 0;
        logic [7:0] dat = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) >= 6) v = ~v;
            if ($urandom_range(0, 7) == 0 || !v) dat = 8'($urandom);
            step(v, dat, $urandom_range(0, 2) == 0);
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1);
    endtask

    initial begin
        reset_n = 1'b0; dValid = 1'b0; data = 8'h00; out_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_ack();
        test_max_delay();
        test_backpressure();
        test_pop_frees();
        test_violation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_protocol_target.md
BUS_PROTOCOL_TARGET -- requirements
Module: bus_protocol_target

Interface
REQ-001 The module SHALL expose the following parameters (name, default, meaning):
  ACK_DLY, 1, cycles from the first high sample of dValid to the dAck pulse; legal values are 1..3.
  DEPTH, 4, receive FIFO entries; must be a power of two, at least 2.
REQ-002 The module SHALL expose the following ports (name, direction, width, meaning):
  clk, in, 1, the single clock; all logic is on its rising edge.
  reset_n, in, 1, asynchronous active-low reset.
  dValid, in, 1, master data-valid.
  data, in, 8, master data.
  dAck, out, 1, target accept pulse.
  out_valid, out, 1, FIFO head is valid.
  out_data, out, 8, FIFO head data, first-word fall-through.
  out_ready, in, 1, consumer pop; a pop occurs when out_valid and out_ready are both high.
  overflow, out, 1, one-cycle pulse when a transfer is acked but its data is dropped.
  proto_err, out, 1, one-cycle pulse on a master protocol violation.

Function
REQ-003 The target SHALL detect a transfer start at edge T0, where dValid is sampled high at T0 and was sampled low at T0-1.
REQ-004 The FSM SHALL have states IDLE, WAIT, ACK and DRAIN.
  IDLE goes to WAIT on a start.
  WAIT goes to ACK when the ack condition holds.
  ACK goes to DRAIN after exactly one cycle.
  DRAIN goes to IDLE when dValid is sampled low.
REQ-005 dAck SHALL be registered and high for exactly one cycle, first sampled high at edge T0+k with k between ACK_DLY and 3.
REQ-006 The ack condition at edge T0+k SHALL be as follows:
  k >= ACK_DLY, and FIFO has space: space means not full, or a pop occurs in the same cycle.
  k == 3 forces the ack regardless of space.
REQ-007 data SHALL be pushed at the edge dAck is registered high, provided space exists.
REQ-008 If a forced ack happens at k == 3 with no space, the data SHALL be dropped and overflow SHALL pulse in the same cycle as dAck.
REQ-009 Push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-010 The FIFO SHALL preserve data order, and its pointers SHALL wrap modulo DEPTH.
REQ-011 out_data SHALL be valid whenever out_valid is high, and SHALL hold stable until popped.
REQ-012 If dValid falls while in WAIT, the FSM SHALL return to IDLE with no push and no dAck.
REQ-013 A new start SHALL NOT be recognised while in ACK or DRAIN.
REQ-014 The WAIT counter SHALL saturate at 3 and SHALL never exceed 2 bits.

Reset
REQ-015 While reset_n is low, the following SHALL hold:
  FSM is in IDLE and the FIFO is empty.
  dAck, out_valid, overflow and proto_err are 0.
  out_data is 0.
REQ-016 Reset assertion mid-transfer SHALL abort the transfer with no push.
REQ-017 After reset_n deasserts, a start SHALL require dValid to be sampled low at least once first.

Configuration
REQ-018 The macro BUS_TARGET_PROTO_CHK_EN SHALL control the protocol checker.
  When defined, proto_err pulses for one cycle on any of:
    dValid falls in WAIT before the ack.
    data changes between T0 and the dAck edge.
    dValid is still high one cycle after the ack (in DRAIN).
  When undefined, proto_err is tied to 0 and no checker logic is synthesised; all other behaviour is unchanged.

Structure
REQ-019 The shared package bus_protocol_pkg SHALL hold the following:
  The FSM state enum.
  DATA_W = 8.
  MAX_VALID_CYC = 4.
  MAX_ACK_DLY = 3.
REQ-020 The FIFO SHALL be a separate sub-module bus_target_fifo, parameterised by DEPTH and DATA_W, with push, pop, full and empty.
REQ-021 Other RTL SHALL NOT duplicate the package constants.

Verification
REQ-022 The bench SHALL cover the following scenarios (stimulus -> required response):
  Basic ack: ACK_DLY=1; dValid high at T0 with data=8'hA5, held until the ack -> dAck high at T0+1 only; out_valid at T0+2 with out_data=8'hA5.
  Maximum delay: ACK_DLY=3; data=8'h3C -> dAck at T0+3; dValid low at T0+4; dValid high for 4 cycles total; no proto_err.
  Backpressure: DEPTH=4, out_ready=0, 4 transfers of 8'h01..8'h04, then a 5th of 8'h05 -> the 5th dAck arrives at T0+3 with an overflow pulse; draining yields 01,02,03,04.
  Pop frees space: FIFO full, and out_ready=1 at T0+1 of a new transfer, ACK_DLY=1 -> dAck at T0+1 with no overflow; order is preserved.
  Violation, checker enabled: dValid drops at T0+1 with ACK_DLY=2 -> no dAck, no push, proto_err pulses once.
  Reset mid-transfer: reset_n low at T0+1 -> all outputs 0 immediately; the next transfer behaves as the basic-ack case.
